// File: rtl/load_sequencer.sv
// load_sequencer
// Moves stream words into the ifmap and weight BRAMs for one layer. The
// ifmap is loaded once per layer. The weights are loaded once per batch. The
// block signals each completed load to the scheduler. It then waits for the
// scheduler's batch_complete before the next weight reload, or before it
// closes the layer.
module load_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    // control
    input  logic              start,
    input  logic [1:0]        layer_id_in,
    input  logic [ADDR_W-1:0] ifmap_words,
    input  logic [ADDR_W-1:0] weight_words,
    // stream input
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    // BRAM write port
    output logic              bram_we,
    output logic              bram_sel,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    // scheduler handshake
    input  logic              batch_complete,
    output logic              ifmap_write_done,
    output logic              weight_write_done,
    output logic              layer_done,
    // status
    output logic [2:0]        batch_idx,
    output logic [1:0]        cur_layer,
    output logic              busy,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IFMAP,
        LOAD_WEIGHT,
        SIGNAL,
        WAIT_BATCH,
        LAYER_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_next;

    // Word counts are stored as "index of the last word". This keeps the
    // end-of-load compare a plain equality. For an all-ones count, the last
    // write lands on 2^ADDR_W-2, and the counter never wraps.
    logic [ADDR_W-1:0] ifmap_last;
    logic [ADDR_W-1:0] weight_last;
    logic [ADDR_W-1:0] addr_cnt;
    logic [2:0]        max_batch;

    // Per-cycle decisions, produced by the next-state logic.
    logic              accept;
    logic              load_last;
    logic              cfg_accept;
    logic              cfg_reject;
    logic              batch_advance;

    // Last batch index for the captured layer.
    always_comb begin
        case (cur_layer)
            2'd0:    max_batch = 3'd7;
            2'd1:    max_batch = 3'd3;
            default: max_batch = 3'd7;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: Sequential state uses non-blocking assignments. Every
        // register then samples values from before the edge, whatever
        // order the always_ff blocks run in.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the per-cycle decisions that drive the datapath.
    always_comb begin
        // NOTE: Every output of this block gets a default before the case.
        // Otherwise, a path that leaves a signal unassigned would infer a
        // latch.
        state_next    = state;
        accept        = 1'b0;
        load_last     = 1'b0;
        cfg_accept    = 1'b0;
        cfg_reject    = 1'b0;
        batch_advance = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if ((ifmap_words != '0) && (weight_words != '0)) begin
                        cfg_accept = 1'b1;
                        state_next = LOAD_IFMAP;
                    end else begin
                        cfg_reject = 1'b1;
                    end
                end
            end

            LOAD_IFMAP: begin
                if (s_valid) begin
                    accept = 1'b1;
                    if (addr_cnt == ifmap_last) begin
                        load_last  = 1'b1;
                        state_next = LOAD_WEIGHT;
                    end
                end
            end

            LOAD_WEIGHT: begin
                if (s_valid) begin
                    accept = 1'b1;
                    if (addr_cnt == weight_last) begin
                        load_last  = 1'b1;
                        state_next = SIGNAL;
                    end
                end
            end

            // A single cycle in which the final write becomes visible. The
            // done pulses are registered out of this state, so they arrive
            // after that write.
            SIGNAL: begin
                state_next = WAIT_BATCH;
            end

            WAIT_BATCH: begin
                if (batch_complete) begin
                    if (batch_idx < max_batch) begin
                        batch_advance = 1'b1;
                        state_next    = LOAD_WEIGHT;
                    end else begin
                        state_next = LAYER_DONE;
                    end
                end
            end

            LAYER_DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Configuration capture and batch counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_layer   <= '0;
            ifmap_last  <= '0;
            weight_last <= '0;
            batch_idx   <= '0;
        end else begin
            if (cfg_accept) begin
                cur_layer   <= layer_id_in;
                ifmap_last  <= ifmap_words - ADDR_ONE;
                weight_last <= weight_words - ADDR_ONE;
                batch_idx   <= '0;
            end else if (batch_advance) begin
                batch_idx <= batch_idx + 3'd1;
            end else if (state == LAYER_DONE) begin
                batch_idx <= '0;
            end
        end
    end

    // Write address counter. It restarts at 0 after the last word of every
    // load, so the next load (ifmap -> weight, or a weight reload) starts at
    // 0 with no extra clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
        end else if (accept) begin
            addr_cnt <= load_last ? '0 : (addr_cnt + ADDR_ONE);
        end
    end

    // Registered BRAM write port: one cycle of latency from stream acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_we    <= 1'b0;
            bram_sel   <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_we <= accept;
            if (accept) begin
                bram_sel   <= (state == LOAD_WEIGHT);
                bram_addr  <= addr_cnt;
                bram_wdata <= s_data;
            end
        end
    end

    // Registered one-cycle pulses for completed loads and rejected starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifmap_write_done  <= 1'b0;
            weight_write_done <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            ifmap_write_done  <= (state == SIGNAL) && (batch_idx == 3'd0);
            weight_write_done <= (state == SIGNAL);
            cfg_err           <= cfg_reject;
        end
    end

    assign s_ready    = (state == LOAD_IFMAP) || (state == LOAD_WEIGHT);
    assign busy       = (state != IDLE);
    assign layer_done = (state == LAYER_DONE);

endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer
// The driver pushes expected BRAM writes and pulse cycles into queues as it
// issues stimulus. The monitor compares each output against the queue heads
// on every falling edge.
module tb_load_sequencer;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    layer_id_in;
    logic [AW-1:0] ifmap_words;
    logic [AW-1:0] weight_words;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          bram_we;
    logic          bram_sel;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic          batch_complete;
    logic          ifmap_write_done;
    logic          weight_write_done;
    logic          layer_done;
    logic [2:0]    batch_idx;
    logic [1:0]    cur_layer;
    logic          busy;
    logic          cfg_err;

    load_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .layer_id_in       (layer_id_in),
        .ifmap_words       (ifmap_words),
        .weight_words      (weight_words),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .bram_we           (bram_we),
        .bram_sel          (bram_sel),
        .bram_addr         (bram_addr),
        .bram_wdata        (bram_wdata),
        .batch_complete    (batch_complete),
        .ifmap_write_done  (ifmap_write_done),
        .weight_write_done (weight_write_done),
        .layer_done        (layer_done),
        .batch_idx         (batch_idx),
        .cur_layer         (cur_layer),
        .busy              (busy),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    // Count of rising edges so far. It is stable when read at a falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t wr_q[$];
    int  ifd_q[$];
    int  wtd_q[$];
    int  ld_q[$];
    int  err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: the queue heads say which outputs must be active at this cycle.
    initial begin
        logic e;
        wr_t  w;
        forever begin
            @(negedge clk);
            e = (wr_q.size() > 0) && (wr_q[0].cyc <= cyc);
            check("bram_we", bram_we, e);
            if (e) begin
                w = wr_q.pop_front();
                check("bram_sel", bram_sel, w.sel);
                check("bram_addr", bram_addr, w.addr);
                check("bram_wdata", bram_wdata, w.data);
            end
            e = (ifd_q.size() > 0) && (ifd_q[0] <= cyc);
            check("ifmap_write_done", ifmap_write_done, e);
            if (e) void'(ifd_q.pop_front());
            e = (wtd_q.size() > 0) && (wtd_q[0] <= cyc);
            check("weight_write_done", weight_write_done, e);
            if (e) void'(wtd_q.pop_front());
            e = (ld_q.size() > 0) && (ld_q[0] <= cyc);
            check("layer_done", layer_done, e);
            if (e) void'(ld_q.pop_front());
            e = (err_q.size() > 0) && (err_q[0] <= cyc);
            check("cfg_err", cfg_err, e);
            if (e) void'(err_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs();
        check("rst_bram_we", bram_we, 1'b0);
        check("rst_bram_sel", bram_sel, 1'b0);
        check("rst_bram_addr", bram_addr, '0);
        check("rst_bram_wdata", bram_wdata, '0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_ifmap_done", ifmap_write_done, 1'b0);
        check("rst_weight_done", weight_write_done, 1'b0);
        check("rst_layer_done", layer_done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_batch_idx", batch_idx, 3'd0);
        check("rst_cur_layer", cur_layer, 2'd0);
    endtask

    // One-cycle start pulse. It is called at a falling edge and returns at
    // the falling edge after the sampling rising edge.
    task automatic do_start(input logic [1:0] layer, input int iw, input int ww, input logic exp_err);
        layer_id_in  = layer;
        ifmap_words  = AW'(iw);
        weight_words = AW'(ww);
        start        = 1'b1;
        if (exp_err) err_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams n words in order. pat[k % 16] gives s_valid in cycle k. With
    // inject set, start and batch_complete are pulsed in cycle 1, which must
    // be ignored mid-load. last_edge is the rising edge that accepts the
    // final word.
    task automatic load(input int n, input logic sel, input logic [DW-1:0] base,
                        input logic [15:0] pat, input logic inject, output int last_edge);
        int   acc;
        int   k;
        logic v;
        wr_t  w;
        acc       = 0;
        k         = 0;
        last_edge = 0;
        while (acc < n) begin
            v       = pat[k % 16];
            s_valid = v;
            s_data  = DW'(base + acc);
            if (inject && (k == 1)) begin
                start          = 1'b1;
                layer_id_in    = 2'd3;
                ifmap_words    = AW'(1);
                weight_words   = AW'(1);
                batch_complete = 1'b1;
            end else begin
                start          = 1'b0;
                batch_complete = 1'b0;
            end
            check("s_ready_load", s_ready, 1'b1);
            if (v) begin
                w.sel  = sel;
                w.addr = AW'(acc);
                w.data = DW'(base + acc);
                w.cyc  = cyc + 1;
                wr_q.push_back(w);
                last_edge = cyc + 1;
                acc++;
            end
            k++;
            @(negedge clk);
        end
        start          = 1'b0;
        batch_complete = 1'b0;
    endtask

    // Runs a whole layer: the ifmap, batch 0 weights, then nb-1 weight
    // reloads, then the closing batch_complete.
    task automatic run_layer(input logic [1:0] layer, input int iw, input int ww, input int nb,
                             input logic [15:0] ifmap_pat, input logic inject);
        int a;
        do_start(layer, iw, ww, 1'b0);
        load(iw, 1'b0, 16'h1000, ifmap_pat, inject, a);
        load(ww, 1'b1, 16'h2000, 16'hFFFF, 1'b0, a);
        s_valid = 1'b0;
        // Both done pulses arrive 2 cycles after the last acceptance.
        ifd_q.push_back(a + 1);
        wtd_q.push_back(a + 1);
        @(negedge clk);
        check("batch_idx_b0", batch_idx, 3'd0);
        check("cur_layer", cur_layer, layer);
        check("busy_wait", busy, 1'b1);
        // A word offered while WAIT_BATCH holds s_ready low must not be written.
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        check("s_ready_wait", s_ready, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        for (int b = 1; b < nb; b++) begin
            batch_complete = 1'b1;
            @(negedge clk);
            batch_complete = 1'b0;
            check("batch_idx_inc", batch_idx, b);
            load(ww, 1'b1, DW'(16'h2000 + b * 16), 16'hFFFF, 1'b0, a);
            s_valid = 1'b0;
            wtd_q.push_back(a + 1);
            @(negedge clk);
        end
        batch_complete = 1'b1;
        ld_q.push_back(cyc + 1);
        @(negedge clk);
        batch_complete = 1'b0;
        check("busy_layer_done", busy, 1'b1);
        @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("batch_idx_idle", batch_idx, 3'd0);
    endtask

    initial begin
        int a;
        rst            = 1'b1;
        start          = 1'b0;
        layer_id_in    = '0;
        ifmap_words    = '0;
        weight_words   = '0;
        s_valid        = 1'b0;
        s_data         = '0;
        batch_complete = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Layer 0: 4 ifmap words, 3 weight words, 8 batches.
        run_layer(2'd0, 4, 3, 8, 16'hFFFF, 1'b0);

        // Layer 1 with single-word ifmap: layer_done after the 4th batch_complete.
        run_layer(2'd1, 1, 2, 4, 16'hFFFF, 1'b0);

        // Rejected starts: zero weight count, then zero ifmap count.
        do_start(2'd0, 5, 0, 1'b1);
        check("busy_cfg_err_w", busy, 1'b0);
        @(negedge clk);
        do_start(2'd1, 0, 3, 1'b1);
        check("busy_cfg_err_i", busy, 1'b0);
        repeat (2) @(negedge clk);

        // Gapped 3-word ifmap with start and batch_complete pulsed mid-load.
        run_layer(2'd1, 3, 3, 4, 16'h5555, 1'b1);

        // Reset after the 2nd ifmap word, then a fresh start.
        do_start(2'd1, 4, 2, 1'b0);
        load(2, 1'b0, 16'h3000, 16'hFFFF, 1'b0, a);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_after_rst", busy, 1'b0);
        run_layer(2'd0, 2, 1, 8, 16'hFFFF, 1'b0);

        // All-ones ifmap count: addresses 0..62 with no wrap.
        run_layer(2'd1, 63, 1, 4, 16'hFFFF, 1'b0);

        repeat (3) @(negedge clk);
        check("wr_q_left", wr_q.size(), 0);
        check("ifd_q_left", ifd_q.size(), 0);
        check("wtd_q_left", wtd_q.size(), 0);
        check("ld_q_left", ld_q.size(), 0);
        check("err_q_left", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
- REQ-001 SHALL have parameter DATA_W, default 16: stream and BRAM write data width.
- REQ-002 SHALL have parameter ADDR_W, default 12: BRAM write address width and word-count width.
- REQ-003 SHALL have ports, in order:
  - clk  in  1  the single clock.
  - rst  in  1  asynchronous, active-high reset.
- REQ-004 SHALL have control ports:
  - start  in  1  one-cycle pulse that begins a layer load sequence.
  - layer_id_in  in  2  layer ID; 0=D1, 1=D2.
  - ifmap_words  in  ADDR_W  ifmap word count.
  - weight_words  in  ADDR_W  weight word count per batch.
- REQ-005 SHALL have stream input ports:
  - s_valid  in  1  stream word valid.
  - s_ready  out  1  stream word accepted when s_valid&&s_ready.
  - s_data  in  DATA_W  stream word.
- REQ-006 SHALL have BRAM write ports:
  - bram_we  out  1  write strobe.
  - bram_sel  out  1  target buffer; 0=ifmap, 1=weight.
  - bram_addr  out  ADDR_W  write address.
  - bram_wdata  out  DATA_W  write data.
- REQ-007 SHALL have handshake ports:
  - batch_complete  in  1  pulse from the scheduler FSM when a batch finishes.
  - ifmap_write_done  out  1  pulse.
  - weight_write_done  out  1  pulse.
  - layer_done  out  1  pulse.
- REQ-008 SHALL have status ports:
  - batch_idx  out  3  current batch.
  - cur_layer  out  2  captured layer ID.
  - busy  out  1  high when state is not IDLE.
  - cfg_err  out  1  pulse on a rejected start.

Function
- REQ-009 SHALL implement states IDLE, LOAD_IFMAP, LOAD_WEIGHT, SIGNAL, WAIT_BATCH, LAYER_DONE.
- REQ-010 On start in IDLE with both counts nonzero, SHALL:
  - capture layer_id_in, ifmap_words and weight_words;
  - clear batch_idx;
  - enter LOAD_IFMAP next cycle.
- REQ-011 On start in IDLE with either count zero, SHALL pulse cfg_err for 1 cycle and remain in IDLE.
- REQ-012 start SHALL be ignored in every state other than IDLE.
- REQ-013 s_ready SHALL be 1 exactly in LOAD_IFMAP and LOAD_WEIGHT.
- REQ-014 For each accepted word, bram_we, bram_sel, bram_addr and bram_wdata SHALL be registered and valid in the next cycle (latency 1).
- REQ-015 bram_addr SHALL start at 0 at each load and increment by 1 per accepted word.
- REQ-016 In LOAD_IFMAP, acceptance of word ifmap_words-1 SHALL move the FSM to LOAD_WEIGHT and reset the address to 0.
- REQ-017 In LOAD_WEIGHT, acceptance of word weight_words-1 SHALL move the FSM to SIGNAL.
- REQ-018 The SIGNAL state SHALL last exactly 1 cycle, followed by WAIT_BATCH.
- REQ-019 In the SIGNAL cycle, weight_write_done SHALL pulse 1 cycle. When the load in progress is for batch 0, ifmap_write_done SHALL pulse in the same cycle (the new-layer indication).
- REQ-020 ifmap_write_done SHALL NOT pulse for batches 1 and above.
- REQ-021 The done pulse SHALL therefore be asserted 2 cycles after the last word is accepted, after the final BRAM write.
- REQ-022 max_batch SHALL be 7 for layer 0, 3 for layer 1, and 7 otherwise.
- REQ-023 In WAIT_BATCH, batch_complete with batch_idx<max_batch SHALL increment batch_idx and enter LOAD_WEIGHT with address 0.
- REQ-024 In WAIT_BATCH, batch_complete with batch_idx==max_batch SHALL enter LAYER_DONE.
- REQ-025 batch_complete SHALL be ignored outside WAIT_BATCH.
- REQ-026 LAYER_DONE SHALL pulse layer_done for 1 cycle, clear batch_idx to 0, and enter IDLE next cycle.
- REQ-027 A stream word presented while s_ready=0 SHALL NOT be written and SHALL NOT advance any counter.
- REQ-028 A gap in s_valid SHALL stall the load without loss of data or address.
- REQ-029 A word count of 1 SHALL complete its load on the first accepted word.
- REQ-030 An ifmap_words or weight_words value of all-ones SHALL write addresses 0..2^ADDR_W-2 without wrap.

Reset
- REQ-031 rst high SHALL asynchronously force state IDLE and set to 0: batch_idx, cur_layer, the address counter, bram_we, bram_addr, bram_wdata, bram_sel, s_ready, all pulse outputs and busy.
- REQ-032 rst asserted mid-load SHALL abandon the load. After release, no done pulse SHALL be emitted until a new start.

Verification
- REQ-033 Layer 0, ifmap_words=4, weight_words=3, s_valid held 1 -> the bench SHALL check:
  - writes ifmap addr 0..3, then weight 0..2;
  - both done pulses in the same cycle, 2 cycles after the 7th acceptance;
  - batch_idx=0.
- REQ-034 Continuing REQ-033, issue 8 batch_complete pulses with weight reloads between them -> the bench SHALL check:
  - weight_write_done only, for batches 1..7;
  - layer_done after the 8th batch_complete;
  - return to IDLE with batch_idx=0.
- REQ-035 Layer 1 -> the bench SHALL check that layer_done follows the 4th batch_complete.
- REQ-036 start with weight_words=0 -> the bench SHALL check a cfg_err pulse, busy remaining 0, and no writes.
- REQ-037 s_valid toggling 1010 during a 3-word load, plus start and batch_complete pulsed mid-load -> the bench SHALL check contiguous addresses 0..2, both pulses ignored, and an unchanged done timing relative to the last acceptance.
- REQ-038 rst pulsed after the 2nd ifmap word, then a fresh start -> the bench SHALL check all outputs at 0 during reset and restart of writes at addr 0.
